// File: rtl/mem_arbiter.sv
// Three-requester single-port RAM arbiter: loader has fixed priority, fetch/data alternate round-robin.
// Latency: grant 1 cycle after IDLE sampling, read data 1 cycle after grant; requests are ignored while busy.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_f,
  input  logic              we_f,
  input  logic [ADDR_W-1:0] addr_f,
  input  logic [DATA_W-1:0] wdata_f,
  input  logic              req_d,
  input  logic              we_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [DATA_W-1:0] wdata_d,
  input  logic              req_l,
  input  logic              we_l,
  input  logic [ADDR_W-1:0] addr_l,
  input  logic [DATA_W-1:0] wdata_l,
  output logic              gnt_f,
  output logic              gnt_d,
  output logic              gnt_l,
  output logic              rvalid_f,
  output logic              rvalid_d,
  output logic              rvalid_l,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  localparam logic [1:0] ID_F = 2'd0;
  localparam logic [1:0] ID_D = 2'd1;
  localparam logic [1:0] ID_L = 2'd2;

  state_t     state_q, state_d;
  cmd_t       cmd_q, win_cmd;
  logic [1:0] id_q, win_id;
  logic       last_data_q;  // 1 when data won the most recent fetch/data arbitration
  logic       any_req;

  assign any_req = req_f | req_d | req_l;

  always_comb begin
    win_id = ID_F;
    if (req_l)
      win_id = ID_L;
    else if (req_f && req_d)
      win_id = last_data_q ? ID_F : ID_D;
    else if (req_d)
      win_id = ID_D;

    win_cmd = '{we: we_f, addr: addr_f, wdata: wdata_f};
    case (win_id)
      ID_D:    win_cmd = '{we: we_d, addr: addr_d, wdata: wdata_d};
      ID_L:    win_cmd = '{we: we_l, addr: addr_l, wdata: wdata_l};
      default: win_cmd = '{we: we_f, addr: addr_f, wdata: wdata_f};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_data_q <= 1'b1;
      id_q        <= ID_F;
      cmd_q       <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && any_req) begin
        id_q  <= win_id;
        cmd_q <= win_cmd;
        // Loader grants must not disturb the fetch/data rotation.
        if (win_id != ID_L)
          last_data_q <= (win_id == ID_D);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_f    = 1'b0;
    gnt_d    = 1'b0;
    gnt_l    = 1'b0;
    rvalid_f = 1'b0;
    rvalid_d = 1'b0;
    rvalid_l = 1'b0;
    rdata    = '0;
    ram_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req)
          state_d = ISSUE;
      end
      ISSUE: begin
        ram_we  = cmd_q.we;
        gnt_f   = (id_q == ID_F);
        gnt_d   = (id_q == ID_D);
        gnt_l   = (id_q == ID_L);
        state_d = cmd_q.we ? IDLE : RESP;
      end
      RESP: begin
        rvalid_f = (id_q == ID_F);
        rvalid_d = (id_q == ID_D);
        rvalid_l = (id_q == ID_L);
        rdata    = ram_rdata;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The command register doubles as the RAM port, so address/data hold between transactions.
  assign ram_addr  = cmd_q.addr;
  assign ram_wdata = cmd_q.wdata;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected grants/read responses, a negedge monitor pops and compares.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_f = 0, we_f = 0, req_d = 0, we_d = 0, req_l = 0, we_l = 0;
  logic [31:0] addr_f = 0, wdata_f = 0, addr_d = 0, wdata_d = 0, addr_l = 0, wdata_l = 0;
  logic        gnt_f, gnt_d, gnt_l, rvalid_f, rvalid_d, rvalid_l, ram_we, busy;
  logic [31:0] rdata, ram_addr, ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .req_f(req_f), .we_f(we_f), .addr_f(addr_f), .wdata_f(wdata_f),
    .req_d(req_d), .we_d(we_d), .addr_d(addr_d), .wdata_d(wdata_d),
    .req_l(req_l), .we_l(we_l), .addr_l(addr_l), .wdata_l(wdata_l),
    .gnt_f(gnt_f), .gnt_d(gnt_d), .gnt_l(gnt_l),
    .rvalid_f(rvalid_f), .rvalid_d(rvalid_d), .rvalid_l(rvalid_l),
    .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] ram_val(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return (a * 32'h9E37) + 32'h1234_5678;
  endfunction

  // Registered-output RAM: data for the command seen at an edge appears after that edge.
  always @(posedge clk) ram_rdata <= ram_val(ram_addr);

  typedef struct {
    bit          is_rv;
    int          id;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_gnt(input int id, input bit we, input logic [31:0] a, input logic [31:0] w, input int c);
    exp_t e;
    e.is_rv = 0; e.id = id; e.we = we; e.addr = a; e.wdata = w; e.rdata = 0; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic push_rv(input int id, input logic [31:0] d, input int c);
    exp_t e;
    e.is_rv = 1; e.id = id; e.we = 0; e.addr = 0; e.wdata = 0; e.rdata = d; e.cyc = c;
    q.push_back(e);
  endtask

  int   m_ng, m_nr, m_id;
  exp_t m_e;
  always @(negedge clk) begin
    m_ng = int'(gnt_f) + int'(gnt_d) + int'(gnt_l);
    m_nr = int'(rvalid_f) + int'(rvalid_d) + int'(rvalid_l);
    if (m_ng > 0) begin
      chk("one_gnt", m_ng, 1);
      m_id = gnt_l ? 2 : (gnt_d ? 1 : 0);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_gnt: got grant id %0d expected none (cycle %0d)", m_id, cyc);
      end else begin
        m_e = q.pop_front();
        chk("gnt_kind", m_e.is_rv, 0);
        chk("gnt_id", m_id, m_e.id);
        chk("gnt_cycle", cyc, m_e.cyc);
        chk("ram_we", ram_we, m_e.we);
        chk("ram_addr", ram_addr, m_e.addr);
        chk("ram_wdata", ram_wdata, m_e.wdata);
      end
    end else begin
      chk("ram_we_off", ram_we, 0);
    end
    if (m_nr > 0) begin
      chk("one_rvalid", m_nr, 1);
      m_id = rvalid_l ? 2 : (rvalid_d ? 1 : 0);
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_rvalid: got rvalid id %0d expected none (cycle %0d)", m_id, cyc);
      end else begin
        m_e = q.pop_front();
        chk("rv_kind", m_e.is_rv, 1);
        chk("rv_id", m_id, m_e.id);
        chk("rv_cycle", cyc, m_e.cyc);
        chk("rdata", rdata, m_e.rdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int id, input string nm);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (id == 0) ? gnt_f : ((id == 1) ? gnt_d : gnt_l);
    end
    if (!seen) begin
      n_chk++; n_fail++;
      $display("FAIL %s: got no grant for id %0d within 20 cycles expected one", nm, id);
    end
  endtask

  task automatic do_reset();
    req_f = 0; req_d = 0; req_l = 0; we_f = 0; we_d = 0; we_l = 0;
    wdata_f = 0; wdata_d = 0; wdata_l = 0;
    reset = 0;
    step(); step();
    reset = 1;
  endtask

  int c;

  initial begin
    // Reset state
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", {gnt_f, gnt_d, gnt_l}, 0);
    chk("rst_rvalid", {rvalid_f, rvalid_d, rvalid_l}, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_rdata", rdata, 0);
    reset = 1;

    // Single fetch read
    step();
    req_f = 1; we_f = 0; addr_f = 32'h10; c = cyc;
    push_gnt(0, 0, 32'h10, 0, c + 1);
    push_rv(0, 32'hDEADBEEF, c + 2);
    wait_gnt(0, "fetch_read");
    step(); req_f = 0;
    repeat (3) step();

    // Data write returns to IDLE right after the grant
    req_d = 1; we_d = 1; addr_d = 32'h40; wdata_d = 32'h12345678; c = cyc;
    push_gnt(1, 1, 32'h40, 32'h12345678, c + 1);
    wait_gnt(1, "data_write");
    step(); req_d = 0; we_d = 0;
    chk("write_busy_after", busy, 0);
    repeat (3) step();

    // Fetch and data held: alternate starting with fetch
    do_reset();
    addr_f = 32'h100; addr_d = 32'h200;
    step();
    req_f = 1; req_d = 1; c = cyc;
    push_gnt(0, 0, 32'h100, 0, c + 1);  push_rv(0, ram_val(32'h100), c + 2);
    push_gnt(1, 0, 32'h200, 0, c + 4);  push_rv(1, ram_val(32'h200), c + 5);
    push_gnt(0, 0, 32'h100, 0, c + 7);  push_rv(0, ram_val(32'h100), c + 8);
    push_gnt(1, 0, 32'h200, 0, c + 10); push_rv(1, ram_val(32'h200), c + 11);
    wait_gnt(0, "rr_f1"); wait_gnt(1, "rr_d1"); wait_gnt(0, "rr_f2"); wait_gnt(1, "rr_d2");
    step(); req_f = 0; req_d = 0;
    repeat (4) step();

    // Loader starves fetch/data, then fetch goes first
    do_reset();
    addr_f = 32'h100; addr_d = 32'h200; addr_l = 32'h300;
    step();
    req_f = 1; req_d = 1; req_l = 1; c = cyc;
    push_gnt(2, 0, 32'h300, 0, c + 1);  push_rv(2, ram_val(32'h300), c + 2);
    push_gnt(2, 0, 32'h300, 0, c + 4);  push_rv(2, ram_val(32'h300), c + 5);
    push_gnt(2, 0, 32'h300, 0, c + 7);  push_rv(2, ram_val(32'h300), c + 8);
    push_gnt(0, 0, 32'h100, 0, c + 10); push_rv(0, ram_val(32'h100), c + 11);
    push_gnt(1, 0, 32'h200, 0, c + 13); push_rv(1, ram_val(32'h200), c + 14);
    wait_gnt(2, "ld1"); wait_gnt(2, "ld2"); wait_gnt(2, "ld3");
    step(); req_l = 0;
    wait_gnt(0, "after_ld_f"); wait_gnt(1, "after_ld_d");
    step(); req_f = 0; req_d = 0;
    repeat (4) step();

    // Reset during ISSUE aborts the read; fresh arbitration afterwards
    do_reset();
    step();
    req_f = 1; addr_f = 32'h24; c = cyc;
    push_gnt(0, 0, 32'h24, 0, c + 1);
    wait_gnt(0, "abort_issue");
    reset = 0;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_ram_we", ram_we, 0);
    chk("abort_rvalid_f", rvalid_f, 0);
    chk("abort_ram_addr", ram_addr, 0);
    reset = 1; c = cyc;
    push_gnt(0, 0, 32'h24, 0, c + 1);
    push_rv(0, ram_val(32'h24), c + 2);
    wait_gnt(0, "post_reset_f");
    step(); req_f = 0;
    repeat (3) step();

    // Fetch pulse while busy with a data read is ignored
    req_d = 1; we_d = 0; addr_d = 32'h60; c = cyc;
    push_gnt(1, 0, 32'h60, 0, c + 1);
    push_rv(1, ram_val(32'h60), c + 2);
    wait_gnt(1, "busy_data");
    step(); req_d = 0; req_f = 1; addr_f = 32'h70;
    step(); req_f = 0;
    repeat (5) step();

    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, RAM address width.
REQ-002 Parameter DATA_W, default 32, RAM data width.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 req_f/we_f/addr_f/wdata_f  input  1/1/ADDR_W/DATA_W  requester 0: instruction fetch.
REQ-006 req_d/we_d/addr_d/wdata_d  input  1/1/ADDR_W/DATA_W  requester 1: data load/store.
REQ-007 req_l/we_l/addr_l/wdata_l  input  1/1/ADDR_W/DATA_W  requester 2: program loader.
REQ-008 gnt_f, gnt_d, gnt_l  output  1 each  one-cycle acceptance pulse per requester.
REQ-009 rvalid_f, rvalid_d, rvalid_l  output  1 each  one-cycle read-data-valid pulse per requester.
REQ-010 rdata  output  DATA_W  shared read data, meaningful only while some rvalid_* is high.
REQ-011 ram_we/ram_addr/ram_wdata  output  1/ADDR_W/DATA_W  single RAM port command.
REQ-012 ram_rdata  input  DATA_W  RAM read data, valid one cycle after the RAM command.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 FSM SHALL have states IDLE, ISSUE, RESP; exactly one transaction in flight.
REQ-015 IDLE: if any req_* is high, the arbiter SHALL latch the winner's id, we, addr, wdata and move to ISSUE next cycle; else stay IDLE.
REQ-016 Priority: req_l SHALL always win; otherwise fetch vs data SHALL alternate round-robin using a last-winner bit (reset value = data, so fetch wins first tie).
REQ-017 Last-winner bit SHALL update only when fetch or data is granted; loader grants leave it unchanged.
REQ-018 ISSUE: ram_addr/ram_wdata/ram_we SHALL present the latched command for exactly one cycle and gnt_<winner> SHALL be high in that cycle only.
REQ-019 ISSUE -> RESP for reads; ISSUE -> IDLE for writes.
REQ-020 RESP: rvalid_<winner> SHALL be high for one cycle with rdata = ram_rdata; then IDLE.
REQ-021 Outside ISSUE, ram_we SHALL be 0; ram_addr/ram_wdata SHALL hold last driven values.
REQ-022 Requesters hold req/we/addr/wdata stable until gnt; arbiter samples command only in IDLE.
REQ-023 A requester dropping req before grant SHALL simply not be selected; no error state.
REQ-024 Read latency req-to-rvalid = 3 cycles from IDLE; write req-to-gnt = 2 cycles; back-to-back throughput one read per 3 cycles, one write per 2.
REQ-025 Requests arriving while busy SHALL be ignored until IDLE; no queueing.
REQ-026 Simultaneous fetch+data+loader SHALL grant loader; fetch/data order then follows the last-winner bit.
REQ-027 At most one gnt_* and at most one rvalid_* SHALL be high in any cycle.

Reset
REQ-028 With reset low at a rising edge, state SHALL become IDLE, last-winner = data, all gnt_*, rvalid_*, ram_we, busy = 0, ram_addr = 0, ram_wdata = 0, rdata = 0.
REQ-029 Reset low during ISSUE or RESP SHALL abort the transaction: no gnt or rvalid for it after the reset edge, and ram_we = 0 from that edge.
REQ-030 First arbitration SHALL occur on the first rising edge with reset high and a req_* high.

Verification
REQ-031 Single fetch read: req_f=1, addr_f=0x10, ram returns 0xDEADBEEF -> gnt_f at cycle 2, ram_addr=0x10, rvalid_f at cycle 3, rdata=0xDEADBEEF.
REQ-032 Data write: req_d=1, we_d=1, addr_d=0x40, wdata_d=0x12345678 -> one-cycle ram_we=1 with that addr/data, gnt_d, no rvalid_d, back to IDLE next cycle.
REQ-033 Fetch and data held high continuously (reads) -> grants alternate f,d,f,d starting with fetch; no two gnt in same cycle.
REQ-034 All three requesting, then loader continuously -> loader granted every transaction; fetch/data starve until req_l drops, then fetch first.
REQ-035 Reset low in the ISSUE cycle of a fetch read -> no rvalid_f, ram_we=0, busy=0 next cycle, fresh arbitration picks fetch after reset release.
REQ-036 req_f pulsed one cycle while busy with a data read -> fetch never granted, rvalid_d unaffected.
